// File: rtl/decode_stage.sv
// RiSC-16 decode stage: field decode, register-file port drive, pending-write
// scoreboard for RAW stalls and a one-entry output register toward execute.
module decode_stage #(
    parameter logic [15:0] RST_PC = 16'h0000
) (
    input  logic        clk0,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_instr,
    input  logic [15:0] in_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [2:0]  out_op,
    output logic [2:0]  out_tgt,
    output logic        out_wr,
    output logic [15:0] out_imm,
    output logic [15:0] out_pc,
    output logic [15:0] out_src1_data,
    output logic [15:0] out_src2_data,
    input  logic        flush,
    input  logic        wb_valid,
    input  logic [2:0]  wb_addr,
    input  logic [15:0] wb_data,
    output logic [2:0]  rf_src1_addr,
    output logic [2:0]  rf_src2_addr,
    output logic [2:0]  rf_tgt_addr,
    output logic [15:0] rf_tgt_data,
    output logic        rf_werf,
    output logic        rf_csb0,
    input  logic [15:0] rf_src1_data,
    input  logic [15:0] rf_src2_data
);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_ADDI = 3'b001;
    localparam logic [2:0] OP_NAND = 3'b010;
    localparam logic [2:0] OP_LUI  = 3'b011;
    localparam logic [2:0] OP_SW   = 3'b100;
    localparam logic [2:0] OP_LW   = 3'b101;
    localparam logic [2:0] OP_BEQ  = 3'b110;

    logic [2:0]         dec_op;
    logic [2:0]         dec_ra;
    logic [2:0]         dec_rb;
    logic [2:0]         dec_rc;
    logic [2:0]         dec_src1;
    logic [2:0]         dec_src2;
    logic [2:0]         dec_tgt;
    logic               dec_wr;
    logic signed [15:0] dec_imm;

    logic [7:0]         pending;
    logic [7:0]         pending_nxt;
    logic               hazard;
    logic               accept;

    logic               vld_p1;
    logic [2:0]         op_p1;
    logic [2:0]         tgt_p1;
    logic               wr_p1;
    logic signed [15:0] imm_p1;
    logic [15:0]        pc_p1;
    logic [2:0]         src1_p1;
    logic [2:0]         src2_p1;

    function automatic logic signed [15:0] sext7(input logic [6:0] v);
        return {{9{v[6]}}, v};
    endfunction

    always_comb begin
        dec_op   = in_instr[15:13];
        dec_ra   = in_instr[12:10];
        dec_rb   = in_instr[9:7];
        dec_rc   = in_instr[2:0];
        dec_src1 = 3'd0;
        dec_src2 = 3'd0;
        dec_tgt  = 3'd0;
        dec_imm  = '0;
        case (dec_op)
            OP_ADD, OP_NAND: begin
                dec_src1 = dec_rb;
                dec_src2 = dec_rc;
                dec_tgt  = dec_ra;
            end
            OP_ADDI, OP_LW: begin
                dec_src1 = dec_rb;
                dec_tgt  = dec_ra;
                dec_imm  = sext7(in_instr[6:0]);
            end
            OP_LUI: begin
                dec_tgt  = dec_ra;
                dec_imm  = {in_instr[9:0], 6'b0};
            end
            OP_SW: begin
                dec_src1 = dec_rb;
                dec_src2 = dec_ra;
                dec_imm  = sext7(in_instr[6:0]);
            end
            OP_BEQ: begin
                dec_src1 = dec_ra;
                dec_src2 = dec_rb;
                dec_imm  = sext7(in_instr[6:0]);
            end
            default: begin
                dec_src1 = dec_rb;
                dec_tgt  = dec_ra;
            end
        endcase
        // Ops without a destination leave dec_tgt at r0, so this covers both terms.
        dec_wr = (dec_tgt != 3'd0);
    end

    // A writeback this cycle lands on the same edge as the read, so the
    // pre-update scoreboard is the right one to stall on.
    assign hazard   = pending[dec_src1] | pending[dec_src2];
    assign in_ready = ~rst & ~flush & (~vld_p1 | out_ready) & ~hazard;
    assign accept   = in_valid & in_ready;

    always_comb begin
        pending_nxt = pending;
        if (wb_valid) pending_nxt[wb_addr] = 1'b0;
        if (flush && vld_p1 && wr_p1) pending_nxt[tgt_p1] = 1'b0;
        if (accept && dec_wr) pending_nxt[dec_tgt] = 1'b1;
        pending_nxt[0] = 1'b0;
    end

    assign rf_csb0      = rst;
    assign rf_werf      = ~wb_valid;
    assign rf_tgt_addr  = wb_addr;
    assign rf_tgt_data  = wb_data;
    // Re-reading the held sources keeps operand data steady during a stall.
    assign rf_src1_addr = accept ? dec_src1 : src1_p1;
    assign rf_src2_addr = accept ? dec_src2 : src2_p1;

    // ---- stage p1: decoded instruction held for execute ----
    always_ff @(posedge clk0) begin
        if (rst) begin
            pending <= '0;
            vld_p1  <= 1'b0;
            op_p1   <= '0;
            tgt_p1  <= '0;
            wr_p1   <= 1'b0;
            imm_p1  <= '0;
            pc_p1   <= RST_PC;
            src1_p1 <= '0;
            src2_p1 <= '0;
        end else begin
            pending <= pending_nxt;
            if (flush)          vld_p1 <= 1'b0;
            else if (accept)    vld_p1 <= 1'b1;
            else if (out_ready) vld_p1 <= 1'b0;
            if (accept) begin
                op_p1   <= dec_op;
                tgt_p1  <= dec_tgt;
                wr_p1   <= dec_wr;
                imm_p1  <= dec_imm;
                pc_p1   <= in_pc;
                src1_p1 <= dec_src1;
                src2_p1 <= dec_src2;
            end
        end
    end

    assign out_valid     = vld_p1;
    assign out_op        = op_p1;
    assign out_tgt       = tgt_p1;
    assign out_wr        = wr_p1;
    assign out_imm       = imm_p1;
    assign out_pc        = pc_p1;
    assign out_src1_data = rf_src1_data;
    assign out_src2_data = rf_src2_data;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios then randomized traffic, all checked
// against an instruction-level reference model and a behavioural register file.
module tb_decode_stage;

    localparam logic [15:0] RST_PC = 16'h0100;

    logic        clk0 = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready, out_wr, flush, wb_valid;
    logic        rf_werf, rf_csb0;
    logic [15:0] in_instr, in_pc, out_imm, out_pc, out_src1_data, out_src2_data;
    logic [15:0] wb_data, rf_tgt_data, rf_src1_data, rf_src2_data;
    logic [2:0]  out_op, out_tgt, wb_addr, rf_src1_addr, rf_src2_addr, rf_tgt_addr;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] m_rf [8];
    logic [7:0]  m_pend;
    logic        m_vld, m_wr, last_rdy;
    logic [2:0]  m_op, m_tgt, m_s1, m_s2;
    logic [15:0] m_imm, m_pc, m_d1, m_d2;
    logic [15:0] rf_mem [8];

    always #5 clk0 = ~clk0;

    decode_stage #(.RST_PC(RST_PC)) dut (
        .clk0(clk0), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_op(out_op), .out_tgt(out_tgt), .out_wr(out_wr), .out_imm(out_imm),
        .out_pc(out_pc), .out_src1_data(out_src1_data), .out_src2_data(out_src2_data),
        .flush(flush), .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .rf_src1_addr(rf_src1_addr), .rf_src2_addr(rf_src2_addr), .rf_tgt_addr(rf_tgt_addr),
        .rf_tgt_data(rf_tgt_data), .rf_werf(rf_werf), .rf_csb0(rf_csb0),
        .rf_src1_data(rf_src1_data), .rf_src2_data(rf_src2_data)
    );

    // Register file stand-in: r0 reads zero, one-cycle read, read-before-write.
    always @(posedge clk0) begin
        if (!rf_csb0) begin
            if (!rf_werf && rf_tgt_addr != 3'd0) rf_mem[rf_tgt_addr] <= rf_tgt_data;
            rf_src1_data <= (rf_src1_addr == 3'd0) ? 16'h0 : rf_mem[rf_src1_addr];
            rf_src2_data <= (rf_src2_addr == 3'd0) ? 16'h0 : rf_mem[rf_src2_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Instruction semantics from the ISA tables, with plain integer arithmetic.
    function automatic void mdec(input logic [15:0] i, output logic [2:0] s1,
                                 output logic [2:0] s2, output logic [2:0] t,
                                 output logic [15:0] imm);
        int op, ra, rb, rc, v;
        op = int'(i[15:13]);
        ra = int'(i[12:10]);
        rb = int'(i[9:7]);
        rc = int'(i[2:0]);
        s1 = 3'((op == 3) ? 0 : (op == 6) ? ra : rb);
        s2 = 3'((op == 0 || op == 2) ? rc : (op == 4) ? ra : (op == 6) ? rb : 0);
        t  = 3'((op == 4 || op == 6) ? 0 : ra);
        v  = int'(i[6:0]);
        if (v >= 64) v = v - 128;
        if (op == 3)                                    imm = 16'(int'(i[9:0]) * 64);
        else if (op == 1 || op == 4 || op == 5 || op == 6) imm = 16'(v);
        else                                            imm = 16'h0;
    endfunction

    // One clock: predict in_ready, advance the model across the edge, compare outputs.
    task automatic cyc();
        logic [2:0]  s1, s2, t, a1, a2;
        logic [15:0] imm;
        logic        rdy, acc;
        #2;
        mdec(in_instr, s1, s2, t, imm);
        rdy = !rst && !flush && (!m_vld || out_ready) && !(m_pend[s1] || m_pend[s2]);
        acc = in_valid && rdy;
        last_rdy = in_ready;
        chk("in_ready", 32'(in_ready), 32'(rdy));
        @(posedge clk0);
        if (rst) begin
            m_pend = 8'h0; m_vld = 1'b0; m_op = 3'd0; m_tgt = 3'd0; m_wr = 1'b0;
            m_imm = 16'h0; m_pc = RST_PC; m_s1 = 3'd0; m_s2 = 3'd0;
        end else begin
            a1 = acc ? s1 : m_s1;
            a2 = acc ? s2 : m_s2;
            m_d1 = m_rf[a1];
            m_d2 = m_rf[a2];
            if (wb_valid && wb_addr != 3'd0) m_rf[wb_addr] = wb_data;
            if (wb_valid) m_pend[wb_addr] = 1'b0;
            if (flush && m_vld && m_wr) m_pend[m_tgt] = 1'b0;
            if (acc && t != 3'd0) m_pend[t] = 1'b1;
            m_pend[0] = 1'b0;
            if (flush) m_vld = 1'b0;
            else if (acc) begin
                m_vld = 1'b1; m_op = in_instr[15:13]; m_tgt = t; m_wr = (t != 3'd0);
                m_imm = imm; m_pc = in_pc; m_s1 = s1; m_s2 = s2;
            end else if (out_ready) m_vld = 1'b0;
        end
        #1;
        chk("out_valid", 32'(out_valid), 32'(m_vld));
        chk("pending", 32'(dut.pending), 32'(m_pend));
        if (m_vld) begin
            chk("out_op", 32'(out_op), 32'(m_op));
            chk("out_tgt", 32'(out_tgt), 32'(m_tgt));
            chk("out_wr", 32'(out_wr), 32'(m_wr));
            chk("out_imm", 32'(out_imm), 32'(m_imm));
            chk("out_pc", 32'(out_pc), 32'(m_pc));
            chk("src1_data", 32'(out_src1_data), 32'(m_d1));
            chk("src2_data", 32'(out_src2_data), 32'(m_d2));
        end
    endtask

    task automatic drain();
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; rst = 1'b0;
        for (int r = 1; r < 8; r++) begin
            if (m_pend[r]) begin
                wb_valid = 1'b1; wb_addr = 3'(r); wb_data = 16'($urandom);
                cyc();
            end
        end
        wb_valid = 1'b0;
        cyc();
    endtask

    task automatic issue(input logic [15:0] instr, input logic [15:0] pc);
        in_valid = 1'b1; in_instr = instr; in_pc = pc;
    endtask

    initial begin
        for (int r = 0; r < 8; r++) m_rf[r] = 16'h0;
        m_pend = 8'h0; m_vld = 1'b0; m_wr = 1'b0; m_op = 3'd0; m_tgt = 3'd0;
        m_s1 = 3'd0; m_s2 = 3'd0; m_imm = 16'h0; m_pc = RST_PC; m_d1 = 16'h0; m_d2 = 16'h0;
        rst = 1'b1; in_valid = 1'b0; in_instr = 16'h0; in_pc = 16'h0; out_ready = 1'b0;
        flush = 1'b0; wb_valid = 1'b0; wb_addr = 3'd0; wb_data = 16'h0;

        // Reset state
        cyc();
        cyc();
        chk("rst_out_pc", 32'(out_pc), 32'(RST_PC));
        chk("rst_out_op", 32'(out_op), 32'(0));
        chk("rst_out_imm", 32'(out_imm), 32'(0));
        chk("rst_csb0", 32'(rf_csb0), 32'(1));
        rst = 1'b0;

        // Preload every register, then r2=5, r3=7
        wb_valid = 1'b1;
        for (int r = 1; r < 8; r++) begin
            wb_addr = 3'(r); wb_data = 16'(r * 16'h1111);
            cyc();
        end
        wb_addr = 3'd2; wb_data = 16'd5; cyc();
        wb_addr = 3'd3; wb_data = 16'd7; cyc();
        wb_valid = 1'b0;
        chk("csb0_run", 32'(rf_csb0), 32'(0));

        // ADD r1,r2,r3
        out_ready = 1'b1;
        issue(16'h0503, 16'h0010);
        cyc();
        chk("add_op", 32'(out_op), 32'(0));
        chk("add_tgt", 32'(out_tgt), 32'(1));
        chk("add_wr", 32'(out_wr), 32'(1));
        chk("add_src1", 32'(out_src1_data), 32'(5));
        chk("add_src2", 32'(out_src2_data), 32'(7));
        chk("add_pend", 32'(dut.pending), 32'(8'h02));
        drain();

        // Immediate forms
        issue(16'h247F, 16'h0011);
        cyc();
        chk("addi_imm", 32'(out_imm), 32'(16'hFFFF));
        issue(16'h6BFF, 16'h0012);
        cyc();
        chk("lui_imm", 32'(out_imm), 32'(16'hFFC0));
        chk("lui_tgt", 32'(out_tgt), 32'(2));
        drain();

        // LW r4 then ADD r5,r4,r4: stall until the cycle after the writeback edge
        issue(16'hB000, 16'h0020);
        cyc();
        issue(16'h1604, 16'h0021);
        cyc();
        chk("raw_stall1", 32'(last_rdy), 32'(0));
        cyc();
        chk("raw_stall2", 32'(last_rdy), 32'(0));
        wb_valid = 1'b1; wb_addr = 3'd4; wb_data = 16'h1234;
        cyc();
        chk("raw_stall_wb", 32'(last_rdy), 32'(0));
        wb_valid = 1'b0;
        cyc();
        chk("raw_accept", 32'(last_rdy), 32'(1));
        chk("raw_src1", 32'(out_src1_data), 32'(16'h1234));
        chk("raw_src2", 32'(out_src2_data), 32'(16'h1234));

        // Execute stalls three cycles with an unrelated writeback in the middle
        issue(16'h0503, 16'h0030);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            wb_valid = (k == 1); wb_addr = 3'd7; wb_data = 16'hBEEF;
            cyc();
            chk("hold_rdy", 32'(last_rdy), 32'(0));
            chk("hold_tgt", 32'(out_tgt), 32'(5));
            chk("hold_pc", 32'(out_pc), 32'(16'h0021));
            chk("hold_src1", 32'(out_src1_data), 32'(16'h1234));
            chk("hold_src2", 32'(out_src2_data), 32'(16'h1234));
        end
        wb_valid = 1'b0;
        drain();

        // Flush of a held ADDI r3 releases r3 for the next instruction
        issue(16'h2C05, 16'h0040);
        cyc();
        chk("flush_pre_pend", 32'(dut.pending), 32'(8'h08));
        in_valid = 1'b0; flush = 1'b1;
        cyc();
        chk("flush_vld", 32'(out_valid), 32'(0));
        chk("flush_pend3", 32'(dut.pending[3]), 32'(0));
        flush = 1'b0;
        issue(16'h0580, 16'h0041);
        cyc();
        chk("flush_next_rdy", 32'(last_rdy), 32'(1));
        chk("flush_next_src1", 32'(out_src1_data), 32'(7));
        drain();

        // Same-cycle writeback and re-set of r6: set wins
        issue(16'hB800, 16'h0050);
        cyc();
        issue(16'hB800, 16'h0051);
        wb_valid = 1'b1; wb_addr = 3'd6; wb_data = 16'h6666;
        cyc();
        chk("setwins_rdy", 32'(last_rdy), 32'(1));
        chk("setwins_pend6", 32'(dut.pending[6]), 32'(1));
        wb_valid = 1'b0;
        drain();

        // Reset in the middle of operation
        issue(16'h0503, 16'h0060);
        cyc();
        in_valid = 1'b0; rst = 1'b1;
        cyc();
        chk("mid_rst_vld", 32'(out_valid), 32'(0));
        chk("mid_rst_pend", 32'(dut.pending), 32'(0));
        chk("mid_rst_pc", 32'(out_pc), 32'(RST_PC));
        rst = 1'b0;

        // Randomized traffic against the model
        for (int n = 0; n < 800; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_instr  = 16'($urandom);
            in_pc     = 16'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            rst       = ($urandom_range(0, 199) == 0);
            if (m_pend != 8'h0 && $urandom_range(0, 2) == 0) begin
                int r;
                r = int'($urandom_range(1, 7));
                while (!m_pend[r]) r = (r % 7) + 1;
                wb_valid = 1'b1; wb_addr = 3'(r);
            end else begin
                wb_valid = ($urandom_range(0, 9) == 0);
                wb_addr  = 3'($urandom_range(0, 7));
            end
            wb_data = 16'($urandom);
            cyc();
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
